// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP32 format constants and types
// Used by the int-to-float converter, adder and normalizer.
package fp_pkg;
  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  localparam logic [31:0] FP_ZERO = 32'h0;
endpackage

// File: rtl/fp_lzc32.sv
// rtl/fp_lzc32.sv - combinational 32-bit leading-zero counter
// Returns 32 for an all-zero input; callers flag zero separately.
module fp_lzc32 (
  input  logic [31:0] value,
  output logic [5:0]  count
);

  always_comb begin
    count = 6'd32;
    // Scanning upward lets the highest set bit win.
    for (int i = 0; i < 32; i++) begin
      if (value[i]) count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/fp_int_to_float.sv
// rtl/fp_int_to_float.sv - two-stage signed int32 to FP32 converter
// Round to nearest even; stage 1 takes magnitude and LZC, stage 2 normalizes and rounds.
module fp_int_to_float
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [FP_EXP_W-1:0] EXP_TOP = FP_EXP_W'(FP_BIAS + 31);

  logic        s1_valid;
  logic        s1_sign;
  logic        s1_zero;
  logic [31:0] s1_mag;
  logic [5:0]  s1_lzc;

  logic [31:0] abs_in;
  logic [5:0]  lzc_in;
  logic        adv2;
  logic        in_xfer;

  assign abs_in = in_data[31] ? (~in_data + 32'd1) : in_data;

  fp_lzc32 u_lzc (
    .value (abs_in),
    .count (lzc_in)
  );

  assign adv2     = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || adv2;
  assign in_xfer  = in_valid && in_ready;

  // Data registers load only on acceptance so an idle stage stays quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_sign  <= in_data[31];
      s1_mag   <= abs_in;
      s1_zero  <= (in_data == 32'd0);
      s1_lzc   <= lzc_in;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  logic [30:0]         norm;
  logic                guard;
  logic                sticky;
  logic                round_up;
  logic [FP_MAN_W:0]   man_rnd;
  logic [FP_EXP_W-1:0] exp_base;
  fp32_t               result;

  assign norm     = 31'(s1_mag << s1_lzc);
  assign guard    = norm[7];
  assign sticky   = |norm[6:0];
  assign round_up = guard && (sticky || norm[8]);
  assign man_rnd  = {1'b0, norm[30:8]} + {{FP_MAN_W{1'b0}}, round_up};
  assign exp_base = EXP_TOP - {2'b00, s1_lzc};

  always_comb begin
    result = FP_ZERO;
    if (!s1_zero) begin
      result.sign = s1_sign;
      // Carry out of the mantissa leaves 1.0 x 2^(e+1).
      if (man_rnd[FP_MAN_W]) begin
        result.exp = exp_base + 8'd1;
        result.man = '0;
      end else begin
        result.exp = exp_base;
        result.man = man_rnd[FP_MAN_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= FP_ZERO;
    end else if (adv2) begin
      out_valid <= 1'b1;
      out_data  <= result;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
